signal_step_sequencer: RTL and testbench



---
 rtl/signal_step_sequencer.sv | 100 ++++++++++
 tb/tb_signal_step_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_step_sequencer.sv
// Step-rate divider, wrapping sine-ROM address and ROM read-latency pipeline; octave speed control from button pulses.
// Latency: inc_data/mem_addr registered; sample/sample_valid arrive MEM_LAT+1 cycles after the inc_data pulse.
// No backpressure: ticks free-run at the current period, and every issued read is delivered in order.
module signal_step_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int DIV_W     = 24,
    parameter int DIV_MIN   = 1,
    parameter int DIV_MAX   = 1048576,
    parameter int DIV_RESET = 48,
    parameter int MEM_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              sw_up,
    input  logic              sw_down,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              inc_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic [DIV_W-1:0]  period,
    output logic              at_min,
    output logic              at_max
);

    // Limits held one bit wider than the period so shifted values compare without wrapping.
    localparam logic [DIV_W:0]   MIN_W   = (DIV_W+1)'(DIV_MIN);
    localparam logic [DIV_W:0]   MAX_W   = (DIV_W+1)'(DIV_MAX);
    localparam logic [DIV_W-1:0] RESET_W = DIV_W'(DIV_RESET);

    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   period_nxt;
    logic               period_chg;
    logic [DIV_W:0]     halved;
    logic [DIV_W:0]     doubled;
    // lat[MEM_LAT-1] marks the cycle in which mem_q holds the word for an earlier tick.
    logic [MEM_LAT-1:0] lat;

    assign at_min = (period == MIN_W[DIV_W-1:0]);
    assign at_max = (period == MAX_W[DIV_W-1:0]);

    // Next period: halve/double with clamping; simultaneous pulses cancel out.
    always_comb begin
        halved     = {1'b0, period} >> 1;
        doubled    = {1'b0, period} << 1;
        period_nxt = period;
        if (sw_up && !sw_down) begin
            period_nxt = (halved < MIN_W) ? MIN_W[DIV_W-1:0] : halved[DIV_W-1:0];
        end else if (sw_down && !sw_up) begin
            period_nxt = (doubled > MAX_W) ? MAX_W[DIV_W-1:0] : doubled[DIV_W-1:0];
        end
        period_chg = (period_nxt != period);
    end

    // Period register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= RESET_W;
        end else begin
            period <= period_nxt;
        end
    end

    // Tick generator: a period change restarts the count and outranks the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            inc_data <= 1'b0;
            mem_addr <= '0;
        end else if (period_chg || !run) begin
            cnt      <= '0;
            inc_data <= 1'b0;
        end else if (cnt == period - DIV_W'(1)) begin
            cnt      <= '0;
            inc_data <= 1'b1;
            mem_addr <= mem_addr + ADDR_W'(1);
        end else begin
            cnt      <= cnt + DIV_W'(1);
            inc_data <= 1'b0;
        end
    end

    // Read pipeline: keeps shifting regardless of run so in-flight reads drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            lat          <= MEM_LAT'({lat, inc_data});
            sample_valid <= lat[MEM_LAT-1];
            if (lat[MEM_LAT-1]) begin
                sample <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_signal_step_sequencer.sv
// Bench for signal_step_sequencer with a 2-cycle ROM model and a tick-schedule reference model.
// Upper period limit is lowered so clamp and interval checks stay short.
module tb_signal_step_sequencer;

    localparam int DIV_MAX_T = 8192;
    localparam int DIV_RST_T = 48;
    localparam int LAT_T     = 2;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        sw_up;
    logic        sw_down;
    logic [9:0]  mem_addr;
    logic [15:0] mem_q;
    logic        inc_data;
    logic [15:0] sample;
    logic        sample_valid;
    logic [23:0] period;
    logic        at_min;
    logic        at_max;

    int checks;
    int failures;

    signal_step_sequencer #(
        .ADDR_W(10), .DATA_W(16), .DIV_W(24), .DIV_MIN(1),
        .DIV_MAX(DIV_MAX_T), .DIV_RESET(DIV_RST_T), .MEM_LAT(LAT_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .sw_up(sw_up), .sw_down(sw_down),
        .mem_addr(mem_addr), .mem_q(mem_q), .inc_data(inc_data), .sample(sample),
        .sample_valid(sample_valid), .period(period), .at_min(at_min), .at_max(at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: random contents, registered address plus registered data.
    logic [15:0] rom [1024];
    logic [9:0]  rom_a;
    always @(posedge clk) begin
        rom_a <= mem_addr;
        mem_q <= rom[rom_a];
    end

    // Reference model: absolute edge at which the next tick is due, plus a queue of
    // (delivery edge, data) for every read issued.
    typedef struct {
        int          due;
        logic [15:0] data;
    } pend_t;
    pend_t       pend_q[$];
    int          m_edge;
    int          m_due;
    logic [23:0] m_period;
    logic [9:0]  m_addr;
    logic        m_inc;
    logic        m_valid;
    logic [15:0] m_sample;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge   <= 0;
            m_due    <= DIV_RST_T;
            m_period <= 24'(DIV_RST_T);
            m_addr   <= '0;
            m_inc    <= 1'b0;
            m_valid  <= 1'b0;
            m_sample <= '0;
            pend_q.delete();
        end else begin : model_step
            int          e;
            int          p;
            int          np;
            logic [9:0]  na;
            pend_t       pe;
            e  = m_edge + 1;
            p  = int'(m_period);
            np = p;
            if (sw_up && !sw_down)      np = (p / 2 < 1) ? 1 : p / 2;
            else if (sw_down && !sw_up) np = (p * 2 > DIV_MAX_T) ? DIV_MAX_T : p * 2;
            na = m_addr;
            m_inc <= 1'b0;
            if (np != p) begin
                m_due <= e + np;
            end else if (!run) begin
                m_due <= e + p;
            end else if (e == m_due) begin
                m_due   <= e + p;
                m_inc   <= 1'b1;
                na      = m_addr + 10'd1;
                pe.due  = e + LAT_T + 1;
                pe.data = rom[na];
                pend_q.push_back(pe);
            end
            if (pend_q.size() != 0 && pend_q[0].due == e) begin
                m_valid  <= 1'b1;
                m_sample <= pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                m_valid <= 1'b0;
            end
            m_addr   <= na;
            m_period <= 24'(np);
            m_edge   <= e;
        end
    end

    logic [53:0] got_v;
    logic [53:0] want_v;
    logic [53:0] reset_v;
    assign got_v   = {inc_data, mem_addr, sample_valid, sample, period, at_min, at_max};
    assign want_v  = {m_inc, m_addr, m_valid, m_sample, m_period,
                      m_period == 24'd1, m_period == 24'(DIV_MAX_T)};
    assign reset_v = {1'b0, 10'd0, 1'b0, 16'd0, 24'(DIV_RST_T), 1'b0, 1'b0};

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; sw_up = 1'b0; sw_down = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got_v !== reset_v) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", got_v, reset_v);
        end
    endtask

    task automatic test_first_tick();
        int first_inc, second_inc, first_sv;
        logic [15:0] first_s;
        first_inc = 0; second_inc = 0; first_sv = 0; first_s = '0;
        run = 1'b1;
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            if (inc_data === 1'b1 && first_inc != 0 && second_inc == 0) second_inc = cyc;
            if (inc_data === 1'b1 && first_inc == 0) first_inc = cyc;
            if (sample_valid === 1'b1 && first_sv == 0) begin
                first_sv = cyc;
                first_s  = sample;
            end
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL first_tick_cycle cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
        end
        checks++;
        if (first_inc != 48) begin
            failures++;
            $display("FAIL first_inc_cycle got=%0d want=48", first_inc);
        end
        checks++;
        if (second_inc != 96) begin
            failures++;
            $display("FAIL second_inc_cycle got=%0d want=96", second_inc);
        end
        checks++;
        if (first_sv != 51 || first_s !== rom[1]) begin
            failures++;
            $display("FAIL first_sample got cyc=%0d data=%h want cyc=51 data=%h", first_sv, first_s, rom[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            run     = ($urandom_range(0, 19) != 0);
            sw_up   = ($urandom_range(0, 29) == 0);
            sw_down = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL random_cycle i=%0d got=%h want=%h", i, got_v, want_v);
            end
        end
        sw_up = 1'b0; sw_down = 1'b0; run = 1'b1;
    endtask

    task automatic test_slow_clamp();
        int t0, gap;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 4; c++) begin
                sw_down = (c == 0);
                @(negedge clk);
                checks++;
                if (got_v !== want_v) begin
                    failures++;
                    $display("FAIL slower_cycle k=%0d got=%h want=%h", k, got_v, want_v);
                end
            end
        end
        sw_down = 1'b0;
        checks++;
        if (period !== 24'(DIV_MAX_T) || at_max !== 1'b1) begin
            failures++;
            $display("FAIL clamp_max got period=%0d at_max=%b want period=%0d at_max=1", period, at_max, DIV_MAX_T);
        end
        t0 = -1; gap = -1;
        for (int cyc = 0; cyc < 3 * DIV_MAX_T && gap < 0; cyc++) begin
            @(negedge clk);
            if (inc_data === 1'b1) begin
                if (t0 >= 0) gap = cyc - t0;
                t0 = cyc;
            end
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL max_interval_cycle cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
        end
        checks++;
        if (gap != DIV_MAX_T) begin
            failures++;
            $display("FAIL max_tick_interval got=%0d want=%0d", gap, DIV_MAX_T);
        end
    endtask

    task automatic test_fast_wrap();
        int n_inc, n_sv;
        logic wrap_seen;
        logic [9:0] prev_addr;
        for (int k = 0; k < 30; k++) begin
            for (int c = 0; c < 4; c++) begin
                sw_up = (c == 0);
                @(negedge clk);
                checks++;
                if (got_v !== want_v) begin
                    failures++;
                    $display("FAIL faster_cycle k=%0d got=%h want=%h", k, got_v, want_v);
                end
            end
            if (k == 9) begin
                checks++;
                if (period !== 24'd8) begin
                    failures++;
                    $display("FAIL ten_up_period got=%0d want=8", period);
                end
            end
        end
        sw_up = 1'b0;
        checks++;
        if (period !== 24'd1 || at_min !== 1'b1) begin
            failures++;
            $display("FAIL clamp_min got period=%0d at_min=%b want period=1 at_min=1", period, at_min);
        end
        n_inc = 0; n_sv = 0; wrap_seen = 1'b0; prev_addr = mem_addr;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            @(negedge clk);
            if (inc_data === 1'b1) n_inc++;
            if (sample_valid === 1'b1) n_sv++;
            if (prev_addr == 10'd1023 && mem_addr == 10'd0) wrap_seen = 1'b1;
            prev_addr = mem_addr;
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL wrap_cycle cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
        end
        checks++;
        if (n_inc != 1100 || n_sv != 1100 || !wrap_seen) begin
            failures++;
            $display("FAIL period_one_stream got inc=%0d sv=%0d wrap=%b want inc=1100 sv=1100 wrap=1", n_inc, n_sv, wrap_seen);
        end
    endtask

    task automatic test_both_and_boundary();
        int wait_n;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                sw_down = (c == 0);
                @(negedge clk);
            end
        end
        sw_down = 1'b0;
        sw_up = 1'b1; sw_down = 1'b1;
        @(negedge clk);
        sw_up = 1'b0; sw_down = 1'b0;
        checks++;
        if (period !== 24'd8 || got_v !== want_v) begin
            failures++;
            $display("FAIL both_pulses got period=%0d want period=8", period);
        end
        wait_n = 0;
        while (inc_data !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (inc_data !== 1'b1) begin
            failures++;
            $display("FAIL boundary_wait_tick got=timeout want=tick");
        end
        repeat (7) @(negedge clk);
        sw_up = 1'b1;
        @(negedge clk);
        sw_up = 1'b0;
        checks++;
        if (inc_data !== 1'b0 || period !== 24'd4) begin
            failures++;
            $display("FAIL terminal_pulse got inc=%b period=%0d want inc=0 period=4", inc_data, period);
        end
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL restart_cycle n=%0d got=%h want=%h", wait_n, got_v, want_v);
            end
        end while (inc_data !== 1'b1 && wait_n < 50);
        checks++;
        if (wait_n != 4) begin
            failures++;
            $display("FAIL restart_interval got=%0d want=4", wait_n);
        end
    endtask

    task automatic test_run_drop();
        int n_inc, n_sv;
        n_inc = 0; n_sv = 0;
        @(negedge clk);
        while (inc_data !== 1'b1 && n_inc < 50) begin
            @(negedge clk);
            n_inc++;
        end
        run = 1'b0;
        n_inc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (inc_data === 1'b1) n_inc++;
            if (sample_valid === 1'b1) n_sv++;
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL run_drop_cycle cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
        end
        checks++;
        if (n_inc != 0 || n_sv != 1) begin
            failures++;
            $display("FAIL run_drop_drain got inc=%0d sv=%0d want inc=0 sv=1", n_inc, n_sv);
        end
    endtask

    task automatic test_reset_mid();
        int n_sv, wait_n;
        run = 1'b1;
        wait_n = 0;
        @(negedge clk);
        while (inc_data !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (got_v !== reset_v) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h", got_v, reset_v);
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_sv = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (sample_valid === 1'b1 || inc_data === 1'b1) n_sv++;
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL post_reset_cycle cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
        end
        checks++;
        if (n_sv != 0) begin
            failures++;
            $display("FAIL late_sample_valid got=%0d want=0", n_sv);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        test_reset();
        test_first_tick();
        test_random();
        test_slow_clamp();
        test_fast_wrap();
        test_both_and_boundary();
        test_run_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
